// File: rtl/fork_pipe_reader.sv
// Sequential RAM reader broadcasting each word to two independently handshaked lanes.
// Optional macro PREFETCH_EN adds a one-entry skid buffer for one-word-per-cycle streaming.
module fork_pipe_reader #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic [ADD_SIZE-1:0]  base_addr,
  input  logic [ADD_SIZE-1:0]  count,
  output logic [ADD_SIZE-1:0]  mem_addr,
  output logic                 mem_rd,
  input  logic [DATA_SIZE-1:0] mem_data,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid1,
  output logic                 valid2,
  input  logic                 ready1,
  input  logic                 ready2,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADD_SIZE-1:0] ONE = {{(ADD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PRESENT, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [ADD_SIZE-1:0]  addr_reg, addr_next;
  logic [ADD_SIZE-1:0]  remaining_reg, remaining_next;
  logic [DATA_SIZE-1:0] data_reg, data_next;
  logic                 valid1_reg, valid1_next;
  logic                 valid2_reg, valid2_next;
  logic                 word_done;

  // A lane that already accepted counts as finished for this word.
  assign word_done = (~valid1_reg | ready1) & (~valid2_reg | ready2);

`ifdef PREFETCH_EN
  logic [ADD_SIZE-1:0]  pf_addr_reg, pf_addr_next;
  logic [ADD_SIZE-1:0]  pf_left_reg, pf_left_next;
  logic                 buf_full_reg, buf_full_next;
  logic                 inflight_reg, inflight_next;
  logic [DATA_SIZE-1:0] buf_data_reg, buf_data_next;
  logic                 have_data, consume, issue;

  // Next word is either parked in the buffer or arriving on mem_data this cycle.
  assign have_data = buf_full_reg | inflight_reg;
  assign consume   = word_done & have_data & (remaining_reg != ONE);
  assign mem_addr  = pf_addr_reg;
`else
  assign mem_addr  = addr_reg;
`endif

  assign data_out = data_reg;
  assign valid1   = valid1_reg;
  assign valid2   = valid2_reg;
  assign busy     = (state_reg != S_IDLE);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    valid1_next    = valid1_reg;
    valid2_next    = valid2_reg;
    mem_rd         = 1'b0;
    done           = 1'b0;
`ifdef PREFETCH_EN
    pf_addr_next   = pf_addr_reg;
    pf_left_next   = pf_left_reg;
    buf_full_next  = buf_full_reg;
    buf_data_next  = buf_data_reg;
    inflight_next  = 1'b0;
    issue          = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          addr_next      = base_addr + ONE;
          remaining_next = count;
          state_next     = (count != '0) ? S_REQ : S_DONE;
`ifdef PREFETCH_EN
          pf_addr_next   = base_addr + ONE;
          pf_left_next   = count;
`endif
        end
      end
      S_REQ: begin
        state_next = S_WAIT;
`ifdef PREFETCH_EN
        issue = 1'b1;
`else
        mem_rd = 1'b1;
`endif
      end
      S_WAIT: begin
        data_next   = mem_data;
        valid1_next = 1'b1;
        valid2_next = 1'b1;
        state_next  = S_PRESENT;
`ifdef PREFETCH_EN
        issue         = (pf_left_reg != '0);
        inflight_next = issue;
        buf_full_next = 1'b0;
`endif
      end
      S_PRESENT: begin
        if (ready1) valid1_next = 1'b0;
        if (ready2) valid2_next = 1'b0;
`ifdef PREFETCH_EN
        buf_full_next = have_data & ~consume;
        if (inflight_reg & ~consume) buf_data_next = mem_data;
        // Only read ahead when the buffer is guaranteed free next cycle.
        issue         = ~buf_full_next & (pf_left_reg != '0);
        inflight_next = issue;
`endif
        if (word_done) begin
          addr_next      = addr_reg + ONE;
          remaining_next = remaining_reg - ONE;
          if (remaining_reg == ONE) state_next = S_DONE;
`ifdef PREFETCH_EN
          else if (have_data) begin
            data_next   = buf_full_reg ? buf_data_reg : mem_data;
            valid1_next = 1'b1;
            valid2_next = 1'b1;
          end
`endif
          else state_next = S_REQ;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
`ifdef PREFETCH_EN
    if (issue) begin
      mem_rd       = 1'b1;
      pf_addr_next = pf_addr_reg + ONE;
      pf_left_next = pf_left_reg - ONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst | clear) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
      valid1_reg    <= 1'b0;
      valid2_reg    <= 1'b0;
`ifdef PREFETCH_EN
      pf_addr_reg   <= '0;
      pf_left_reg   <= '0;
      buf_full_reg  <= 1'b0;
      inflight_reg  <= 1'b0;
      buf_data_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
      valid1_reg    <= valid1_next;
      valid2_reg    <= valid2_next;
`ifdef PREFETCH_EN
      pf_addr_reg   <= pf_addr_next;
      pf_left_reg   <= pf_left_next;
      buf_full_reg  <= buf_full_next;
      inflight_reg  <= inflight_next;
      buf_data_reg  <= buf_data_next;
`endif
    end
  end

endmodule

// File: doc/fork_pipe_reader.md
Name: fork_pipe_reader

Overview:
- Sequential RAM reader: the consuming end of the result stream that the Euler join stage writes into RAM.
- On start, it reads COUNT words from consecutive addresses after a base address.
- Each word is broadcast to two downstream pipes, each lane with its own valid/ready handshake.
- Feeds the next Euler iteration; it replaces the hand-sequenced readback path.

Parameters:
ADD_SIZE, 16, RAM address width; also the width of base_addr and the word counter.
DATA_SIZE, 16, RAM data word width.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-high.
clear  in  1  synchronous abort; same effect as rst but intended for use between iterations.
start  in  1  one-cycle request; sampled only in IDLE.
base_addr  in  ADD_SIZE  address preceding the first word; captured on start.
count  in  ADD_SIZE  number of words to read; captured on start.
mem_addr  out  ADD_SIZE  RAM read address.
mem_rd  out  1  RAM read strobe; read data valid on mem_data one cycle later.
mem_data  in  DATA_SIZE  RAM read data.
data_out  out  DATA_SIZE  current word, shared by both lanes.
valid1  out  1  lane 1 word available.
valid2  out  1  lane 2 word available.
ready1  in  1  lane 1 accepts when valid1 & ready1.
ready2  in  1  lane 2 accepts when valid2 & ready2.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last word is accepted by both lanes.

Behaviour:
- Reset (rst or clear high at a clock edge)
  - Next state IDLE; address register = 0; remaining counter = 0.
  - Outputs: mem_rd=0, mem_addr=0, data_out=0, valid1=valid2=0, busy=0, done=0.
  - Applies mid-operation: transfer aborted, no done pulse, the partially presented word is dropped.
- States: IDLE, REQ, WAIT, PRESENT, DONE.
- IDLE
  - start=1: capture addr=base_addr+1 (mod 2^ADD_SIZE) and remaining=count.
  - Go to REQ if count!=0, else DONE.
  - start is ignored in all states other than IDLE.
- REQ: mem_rd=1, mem_addr=addr; go to WAIT.
- WAIT: mem_rd=0; data_out<=mem_data at the end of the cycle; set valid1=valid2=1; go to PRESENT.
- PRESENT
  - Each lane clears its own valid on its handshake; the lanes are independent.
  - Both handshakes in the same cycle complete the word.
  - A lane that has already accepted must not see valid again for the same word.
  - data_out holds stable while either valid is high.
  - When both lanes have accepted: addr<=addr+1 (wraps 2^ADD_SIZE-1 -> 0), remaining<=remaining-1.
  - Then go to DONE if remaining was 1, else REQ.
- DONE: done=1 for exactly one cycle, busy=1; go to IDLE.
- Latency (start sampled at edge E): mem_rd high in cycle E+1; valid1/valid2 high from cycle E+3.
- Throughput: one word per 3 cycles when both ready are tied high.
- count=0: no RAM access; done pulses in the cycle after the start edge.
- Only bits [ADD_SIZE-1:0] are used in address arithmetic; no overflow flag.

Optional Feature:
- Macro PREFETCH_EN.
- Defined:
  - During PRESENT, the next word's read is issued (mem_rd=1, addr+1) if remaining>1, into a one-entry skid buffer.
  - On word completion, if the buffer is full, it loads data_out directly and re-asserts both valids the next cycle.
  - Sustained throughput is one word per cycle with both ready high.
  - First-word latency, reset/clear behaviour and done timing relative to the last acceptance are unchanged.
  - clear empties the buffer.
- Undefined: no buffer; timing exactly as in Behaviour.

Test Plan:
- rst then start, base_addr=0x0010, count=3; RAM[0x11..0x13]=0x0A00,0x0B00,0x0C00; ready1=ready2=1 -> mem_addr 0x11,0x12,0x13 in order; data_out sequence 0x0A00,0x0B00,0x0C00; first valid at E+3; done single pulse after 3rd acceptance; busy low afterwards.
- Lane skew: count=1, ready1=1 always, ready2 held 0 for 4 cycles -> valid1 drops after 1 cycle; valid2 held 5 cycles with data_out stable; done one cycle after ready2 rises.
- start with count=0 -> no mem_rd; done=1 in cycle E+1; return to IDLE.
- Wrap: base_addr=0xFFFE, count=3 -> addresses 0xFFFF, 0x0000, 0x0001.
- clear asserted in PRESENT of word 2 of 4 -> next cycle all outputs 0, busy=0, no done; a fresh start works normally.
- PREFETCH_EN defined, count=4, both ready high -> valids high continuously for 4 consecutive cycles after the first word; data correct and in order; done once.
